// File: rtl/data_cache_miss_controller.sv
// Data cache miss sequencer: stalls the data memory stage on a miss, writes back a dirty
// victim, refills the line from the next level, strobes the fill, and counts misses.
`timescale 1ns / 1ps
module data_cache_miss_controller #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned D_CACHE_LW_WIDTH  = 3,
  parameter int unsigned D_CACHE_SW_WIDTH  = 2,
  parameter int unsigned LINE_OFFSET_WIDTH = 4,
  parameter int unsigned MISS_COUNT_WIDTH  = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD,
  input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE,
  input  logic [DATA_WIDTH-1:0]       ACCESS_ADDRESS,
  input  logic                        CACHE_HIT,
  input  logic                        VICTIM_DIRTY,
  input  logic [DATA_WIDTH-1:0]       VICTIM_ADDRESS,
  input  logic                        L2_REQ_READY,
  input  logic                        L2_RESP_VALID,
  output logic                        STALL_DATA_MEMORY_STAGE,
  output logic                        L2_REQ_VALID,
  output logic                        L2_REQ_WRITE,
  output logic [DATA_WIDTH-1:0]       L2_REQ_ADDRESS,
  output logic                        CACHE_FILL_ENABLE,
  output logic [MISS_COUNT_WIDTH-1:0] MISS_COUNT
);

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbWait,
    StRfReq,
    StRfWait,
    StFill
  } state_e;

  localparam logic [DATA_WIDTH-1:0]       LineMask = {DATA_WIDTH{1'b1}} << LINE_OFFSET_WIDTH;
  localparam logic [MISS_COUNT_WIDTH-1:0] CountMax = {MISS_COUNT_WIDTH{1'b1}};

  state_e                      state_q, state_d;
  logic [DATA_WIDTH-1:0]       miss_line_q, miss_line_d;
  logic [DATA_WIDTH-1:0]       req_addr_q, req_addr_d;
  logic [MISS_COUNT_WIDTH-1:0] miss_count_q, miss_count_d;

  logic access;
  logic miss;
  logic req_valid;
  logic req_write;
  logic fill;

  assign access = (DATA_CACHE_LOAD != '0) || (DATA_CACHE_STORE != '0);
  assign miss   = access && !CACHE_HIT;

  always_comb begin
    state_d      = state_q;
    miss_line_d  = miss_line_q;
    req_addr_d   = req_addr_q;
    miss_count_d = miss_count_q;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    fill         = 1'b0;
    case (state_q)
      StIdle: begin
        if (miss) begin
          miss_line_d  = ACCESS_ADDRESS & LineMask;
          miss_count_d = (miss_count_q == CountMax) ? miss_count_q : miss_count_q + 1'b1;
          if (VICTIM_DIRTY) begin
            state_d    = StWbReq;
            req_addr_d = VICTIM_ADDRESS & LineMask;
          end else begin
            state_d    = StRfReq;
            req_addr_d = ACCESS_ADDRESS & LineMask;
          end
        end
      end
      StWbReq: begin
        req_valid = 1'b1;
        req_write = 1'b1;
        if (L2_REQ_READY) state_d = StWbWait;
      end
      StWbWait: begin
        if (L2_RESP_VALID) begin
          req_addr_d = miss_line_q;
          state_d    = StRfReq;
        end
      end
      StRfReq: begin
        req_valid = 1'b1;
        if (L2_REQ_READY) state_d = StRfWait;
      end
      StRfWait: begin
        if (L2_RESP_VALID) state_d = StFill;
      end
      StFill: begin
        fill    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      miss_line_q  <= '0;
      req_addr_q   <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_line_q  <= miss_line_d;
      req_addr_q   <= req_addr_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Strobes are held low while reset is asserted so an abandoned request never leaks out.
  assign L2_REQ_VALID            = req_valid && !RST;
  assign L2_REQ_WRITE            = req_write && !RST;
  assign CACHE_FILL_ENABLE       = fill && !RST;
  assign L2_REQ_ADDRESS          = req_addr_q;
  assign MISS_COUNT              = miss_count_q;
  assign STALL_DATA_MEMORY_STAGE = (state_q != StIdle) || miss;

endmodule

// File: doc/data_cache_miss_controller.md
Name: data_cache_miss_controller

Overview:
Sequences the data cache on behalf of the data memory stage. It detects a miss on the load or store access currently held in the data memory stage pipeline register and drives STALL_DATA_MEMORY_STAGE. It writes back a dirty victim line, refills the missing line from the next-level memory through a valid/ready request with a response strobe, then strobes the cache fill. It also keeps a saturating miss counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, address width.
D_CACHE_LW_WIDTH, 3, width of the load-type code; 0 means no load.
D_CACHE_SW_WIDTH, 2, width of the store-type code; 0 means no store.
LINE_OFFSET_WIDTH, 4, byte-offset bits in a cache line (16-byte lines).
MISS_COUNT_WIDTH, 16, width of the miss counter.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
DATA_CACHE_LOAD  in  D_CACHE_LW_WIDTH  load code of the access in the data memory stage.
DATA_CACHE_STORE  in  D_CACHE_SW_WIDTH  store code of the access in the data memory stage.
ACCESS_ADDRESS  in  DATA_WIDTH  byte address of the access (the ALU output).
CACHE_HIT  in  1  tag match for ACCESS_ADDRESS; combinational from the cache.
VICTIM_DIRTY  in  1  the line selected for replacement is dirty.
VICTIM_ADDRESS  in  DATA_WIDTH  line address of the victim.
L2_REQ_READY  in  1  next level accepts the request.
L2_RESP_VALID  in  1  one-cycle strobe: the next level has completed the accepted request.
STALL_DATA_MEMORY_STAGE  out  1  freeze the data memory stage and all upstream stages.
L2_REQ_VALID  out  1  request valid.
L2_REQ_WRITE  out  1  1 = write back the victim, 0 = refill.
L2_REQ_ADDRESS  out  DATA_WIDTH  line-aligned request address.
CACHE_FILL_ENABLE  out  1  one-cycle strobe: the cache writes the refilled line and clears its dirty bit.
MISS_COUNT  out  MISS_COUNT_WIDTH  number of misses since reset; saturates.

Behaviour:
- Definitions:
  - access = (DATA_CACHE_LOAD != 0) OR (DATA_CACHE_STORE != 0). Both codes non-zero together counts as one access.
  - miss = access AND NOT CACHE_HIT.
- States are IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT and FILL. The state resets to IDLE.
- Reset values: L2_REQ_VALID=0, L2_REQ_WRITE=0, L2_REQ_ADDRESS=0, CACHE_FILL_ENABLE=0, MISS_COUNT=0. STALL_DATA_MEMORY_STAGE follows its definition below (1 during reset if a miss is present).
- STALL_DATA_MEMORY_STAGE = (state != IDLE) OR (state == IDLE AND miss). It is combinational so the pipeline freezes in the same cycle the miss is detected.
- L2_REQ_VALID, L2_REQ_WRITE and CACHE_FILL_ENABLE are decoded from the state. L2_REQ_ADDRESS is a register.
- IDLE:
  - On miss, latch miss_line = ACCESS_ADDRESS with its low LINE_OFFSET_WIDTH bits cleared.
  - Increment MISS_COUNT (holds at all-ones).
  - If VICTIM_DIRTY, go to WB_REQ and load L2_REQ_ADDRESS with VICTIM_ADDRESS, low bits cleared.
  - Otherwise go to RF_REQ and load L2_REQ_ADDRESS with miss_line.
  - A hit, or no access, stays in IDLE with no side effects.
- WB_REQ: VALID=1, WRITE=1. VALID and ADDRESS are held stable until the cycle with L2_REQ_READY=1, then go to WB_WAIT.
- WB_WAIT: VALID=0. On L2_RESP_VALID, load L2_REQ_ADDRESS with miss_line and go to RF_REQ.
- RF_REQ: VALID=1, WRITE=0. Held until L2_REQ_READY, then go to RF_WAIT.
- RF_WAIT: VALID=0. On L2_RESP_VALID, go to FILL.
- FILL: CACHE_FILL_ENABLE=1 for exactly one cycle, then go to IDLE.
- Back in IDLE, CACHE_HIT for the same access is now 1, so the stall drops. The access completes as a hit, and the store writes the freshly filled line.
- Latency:
  - Clean miss: the stall lasts 1 (IDLE) + refill handshake + response wait + 1 (FILL) cycles.
  - With zero-wait READY and a response strobe the cycle after acceptance, the stall is 4 cycles.
- L2_RESP_VALID is ignored in IDLE, WB_REQ, RF_REQ and FILL.
- Changes on ACCESS_ADDRESS or the load/store codes outside IDLE are ignored; the pipeline is frozen.
- Back-to-back misses: the IDLE cycle after FILL re-evaluates the access and may start a new miss immediately.
- RST asserted in any state returns to IDLE at the next edge. L2_REQ_VALID deasserts in that same cycle, and any outstanding request is abandoned. The next level is reset by the same RST.
- Simultaneous L2_REQ_READY and L2_RESP_VALID in a REQ state: READY is honoured and RESP is ignored.

Test Plan:
- Clean load miss: DATA_CACHE_LOAD=3'b010, ACCESS_ADDRESS=0x0000_1234, CACHE_HIT=0, VICTIM_DIRTY=0, READY=1, RESP one cycle after accept -> stall high 4 cycles; single request WRITE=0 at ADDRESS=0x0000_1230; FILL strobe in cycle 4; MISS_COUNT=1.
- Dirty store miss: DATA_CACHE_STORE=2'b11, ACCESS_ADDRESS=0x8000_00F8, VICTIM_ADDRESS=0x4000_00F0, VICTIM_DIRTY=1 -> write request at 0x4000_00F0, then refill request at 0x8000_00F0, then FILL; stall high throughout.
- Hit, or no access (codes 0 and CACHE_HIT=0) -> stall 0, VALID never asserted, MISS_COUNT unchanged.
- Backpressure: READY held low 5 cycles in RF_REQ -> VALID=1 and ADDRESS stable for all 5 cycles; exactly one handshake on the READY edge; RESP during RF_REQ ignored.
- Reset mid-refill: RST asserted in RF_WAIT -> next cycle state IDLE, VALID=0, MISS_COUNT=0, no FILL strobe.
- Saturation with MISS_COUNT_WIDTH=4: 17 consecutive clean misses -> MISS_COUNT reads 15 after the 15th miss and stays 15.
